seven_seg_scan_driver: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Latches a packed hex word and decodes each nibble to segments, rotating one digit at a time at a programmable refresh rate.
- Sits between the datapath/register logic and the board display pins, and replaces per-digit combinational decoders.
- Updates are frame-coherent: a new value never appears mid-scan.

---
 rtl/seven_seg_pkg.sv | 37 +++
 rtl/seven_seg_refresh_timer.sv | 48 ++++
 rtl/seven_seg_scan_driver.sv | 125 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// blank-segment pattern, hex-to-segment decode and digit-index sizing.
package seven_seg_pkg;

  // All segments dark (active low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Width of the digit index; a single-digit display still needs one bit.
  function automatic int idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seven_seg_refresh_timer.sv
// Refresh timer: per-digit clock divider plus digit index counter.
// Flags the anti-ghosting guard window, the first cycle of each digit slot
// and the frame boundary (the cycle on which the index wraps back to 0).
module seven_seg_refresh_timer
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GUARD_CYC  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic [idx_width(NUM_DIGITS)-1:0] index,
  output logic                             guard,
  output logic                             digit_first,
  output logic                             frame_boundary
);

  localparam int             IW        = idx_width(NUM_DIGITS);
  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  GUARD_END = CW'(GUARD_CYC);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap           = (count == CNT_LAST);
  assign frame_boundary = wrap && (index == IDX_LAST);
  assign guard          = (count < GUARD_END);
  assign digit_first    = (count == '0);

  // Divider counts 0..CLK_DIV-1; each wrap advances the digit index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      index <= '0;
    end else if (wrap) begin
      count <= '0;
      index <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver. Loads land in a shadow
// register and are copied to the displayed (active) register only at a
// frame boundary, so a new value never appears mid-scan. All display
// outputs are registered, one cycle behind the refresh timer.
// Optional feature: define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GUARD_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int IW = idx_width(NUM_DIGITS);

  logic [IW-1:0]           index;
  logic                    guard;
  logic                    digit_first;
  logic                    frame_boundary;

  logic [4*NUM_DIGITS-1:0] value_sh, value_act;
  logic [NUM_DIGITS-1:0]   blank_sh, blank_act;
  logic [NUM_DIGITS-1:0]   blank_next;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [3:0]              nibble;
  logic                    digit_blank;

  seven_seg_refresh_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .CLK_DIV    (CLK_DIV),
    .GUARD_CYC  (GUARD_CYC)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .index          (index),
    .guard          (guard),
    .digit_first    (digit_first),
    .frame_boundary (frame_boundary)
  );

`ifdef SEVEN_SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  seen_nonzero;

  // Leading-zero mask: every digit above the top nonzero nibble; digit 0 never.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    lz_mask      = '0;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (value_sh[i*4 +: 4] != 4'h0) seen_nonzero = 1'b1;
      lz_mask[i] = ~seen_nonzero;
    end
  end

  assign blank_next = blank_sh | lz_mask;
`else
  assign blank_next = blank_sh;
`endif

  // Shadow/active handover: loads fill the shadow, the boundary publishes it.
  // A load coincident with the boundary stays in the shadow for next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_sh  <= '0;
      value_act <= '0;
      blank_sh  <= '1;
      blank_act <= '1;
      pending   <= 1'b0;
    end else begin
      if (frame_boundary && pending) begin
        value_act <= value_sh;
        blank_act <= blank_next;
      end
      if (load) begin
        value_sh <= value_in;
        blank_sh <= blank_in;
      end
      pending <= load || (pending && !frame_boundary);
    end
  end

  // Select the current digit's nibble, blank bit and one-hot-low anode.
  always_comb begin
    nibble      = 4'h0;
    digit_blank = 1'b1;
    an_lit      = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IW'(i)) begin
        nibble      = value_act[i*4 +: 4];
        digit_blank = blank_act[i];
        an_lit[i]   = 1'b0;
      end
    end
  end

  // Registered display outputs; dark during the guard window or when blanked.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n       <= SEG_OFF;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= digit_first && (index == '0);
      if (guard || digit_blank) begin
        seg_n <= SEG_OFF;
        an_n  <= '1;
      end else begin
        seg_n <= hex_to_seg(nibble);
        an_n  <= an_lit;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (4 digits, CLK_DIV=8, GUARD_CYC=1).
// The stimulus process pushes the expected picture of the next frame; the
// monitor pops one entry at each frame_start and checks every cycle of it.
// The display comes out of reset dark: blank registers reset to all ones.
module tb_seven_seg_scan_driver;

  localparam int ND    = 4;
  localparam int CD    = 8;
  localparam int GC    = 1;
  localparam int FRAME = ND * CD;

  typedef struct packed {
    logic [3:0]      lit;   // digit expected lit (else anodes stay off)
    logic [3:0][6:0] seg;   // expected segments for lit digits
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;
  logic        pending;

  frame_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     cur_off = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (CD),
    .GUARD_CYC  (GC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value_in    (value_in),
    .blank_in    (blank_in),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start),
    .pending     (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic frame_t mk(input logic [3:0] lit, input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
    frame_t f;
    f.lit = lit;
    f.seg = {s3, s2, s1, s0};
    return f;
  endfunction

  // Monitor: on frame_start, pop an expected frame and check all its cycles.
  initial begin
    frame_t      e;
    logic [3:0]  an_req;
    logic [6:0]  seg_req;
    logic        chk_seg;
    int          k;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int off = 0; off < FRAME; off++) begin
          if (off > 0) @(negedge clk);
          k = off / CD;
          chk_seg = 1'b1;
          if ((off % CD) < GC) begin
            an_req  = 4'hF;
            seg_req = 7'h7F;
          end else if (e.lit[k]) begin
            an_req  = ~(4'b0001 << k);
            seg_req = e.seg[k];
          end else begin
            an_req  = 4'hF;
            seg_req = 7'h00;
            chk_seg = 1'b0;
          end
          check($sformatf("frame off=%0d {fs,an_n,seg_n}", off),
                {frame_start, an_n, chk_seg ? seg_n : 7'h00},
                {(off == 0), an_req, seg_req});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cur_off++;
  endtask

  task automatic skip_to(input int off);
    while (cur_off < off) step();
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    if (frame_start !== 1'b1) check("frame_start timeout", frame_start, 1);
    cur_off = 0;
  endtask

  // Land on offset 1 of the next frame, safely after the monitor's pop.
  task automatic next_frame();
    int n;
    wait_frame(n);
    step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b);
    value_in = v;
    blank_in = b;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    int n;
    frame_t dark;
    dark = mk(4'b0000, 7'h00, 7'h00, 7'h00, 7'h00);

    repeat (3) @(negedge clk);
    check("reset seg_n", seg_n, 7'h7F);
    check("reset an_n", an_n, 4'hF);
    check("reset frame_start", frame_start, 0);
    check("reset pending", pending, 0);

    exp_q.push_back(dark);
    reset = 1'b0;

    next_frame();                                  // frame 0
    exp_q.push_back(dark);
    check("pending idle", pending, 0);

    next_frame();                                  // frame 1: load 12AF mid-frame
    exp_q.push_back(mk(4'hF, 7'h79, 7'h24, 7'h08, 7'h0E));
    skip_to(10);
    do_load(16'h12AF, 4'b0000);
    check("pending after load", pending, 1);
    skip_to(30);
    check("pending before boundary", pending, 1);
    step();
    check("pending after boundary", pending, 0);

    next_frame();                                  // frame 2: last load wins
    exp_q.push_back(mk(4'hF, 7'h24, 7'h24, 7'h24, 7'h24));
    skip_to(5);
    do_load(16'h1111, 4'b0000);
    skip_to(15);
    do_load(16'h2222, 4'b0000);
    check("pending double load", pending, 1);

    next_frame();                                  // frame 3: load on boundary
    exp_q.push_back(mk(4'hF, 7'h19, 7'h19, 7'h19, 7'h19));
    skip_to(10);
    do_load(16'h4444, 4'b0000);
    skip_to(30);
    do_load(16'h5555, 4'b0000);
    check("pending coincident load", pending, 1);

    next_frame();                                  // frame 4 shows 4444
    exp_q.push_back(mk(4'hF, 7'h12, 7'h12, 7'h12, 7'h12));
    skip_to(31);
    check("pending after deferred apply", pending, 0);

    next_frame();                                  // frame 5: blank mask
    exp_q.push_back(mk(4'b0101, 7'h00, 7'h00, 7'h00, 7'h00));
    skip_to(5);
    do_load(16'h8888, 4'b1010);

    next_frame();                                  // frame 6: 0050
`ifdef SEVEN_SEG_LZB_EN
    exp_q.push_back(mk(4'b0011, 7'h00, 7'h00, 7'h12, 7'h40));
`else
    exp_q.push_back(mk(4'hF, 7'h40, 7'h40, 7'h12, 7'h40));
`endif
    skip_to(5);
    do_load(16'h0050, 4'b0000);

    next_frame();                                  // frame 7: 0000
`ifdef SEVEN_SEG_LZB_EN
    exp_q.push_back(mk(4'b0001, 7'h00, 7'h00, 7'h00, 7'h40));
`else
    exp_q.push_back(mk(4'hF, 7'h40, 7'h40, 7'h40, 7'h40));
`endif
    skip_to(5);
    do_load(16'h0000, 4'b0000);

    next_frame();                                  // frame 8: pending value to lose
    skip_to(5);
    do_load(16'h9999, 4'b0000);
    check("pending before reset", pending, 1);

    next_frame();                                  // frame 9: reset in digit 2
    skip_to(18);
    reset = 1'b1;
    step();
    check("mid-frame reset an_n", an_n, 4'hF);
    check("mid-frame reset seg_n", seg_n, 7'h7F);
    check("mid-frame reset pending", pending, 0);
    check("mid-frame reset frame_start", frame_start, 0);
    exp_q.push_back(dark);
    reset = 1'b0;
    wait_frame(n);
    check("restart latency cycles", n, 1);
    step();
    exp_q.push_back(mk(4'hF, 7'h79, 7'h24, 7'h30, 7'h19));
    skip_to(5);
    do_load(16'h1234, 4'b0000);

    next_frame();                                  // shows 1234
    next_frame();
    check("scoreboard drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
